// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, condition-code and flag definitions
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LHB    = 4'b1010,
    OP_LLB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    CCC_NEQ    = 3'b000,
    CCC_EQ     = 3'b001,
    CCC_GT     = 3'b010,
    CCC_LT     = 3'b011,
    CCC_GTE    = 3'b100,
    CCC_LTE    = 3'b101,
    CCC_OVFL   = 3'b110,
    CCC_UNCOND = 3'b111
  } ccc_t;

  // Bit positions inside the {N,V,Z} flag vector.
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    FC_ALL    = 2'd0,
    FC_Z_ONLY = 2'd1,
    FC_NONE   = 2'd2
  } flag_class_t;

  // Which flags an EX opcode is allowed to update.
  function automatic flag_class_t flag_class(input logic [3:0] op);
    flag_class_t fc;
    case (op)
      OP_ADD, OP_SUB:                 fc = FC_ALL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FC_Z_ONLY;
      default:                        fc = FC_NONE;
    endcase
    return fc;
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// rtl/flag_branch_unit_if.sv - EX/ID to flag/branch unit signal bundle
interface flag_branch_unit_if #(
  parameter int PC_W = 16
);

  logic            ex_valid;
  logic [3:0]      ex_opcode;
  logic [2:0]      alu_nvz;
  logic            stall;
  logic            br_valid;
  logic [2:0]      br_ccc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_plus2;
  logic [2:0]      flags;
  logic            br_taken;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;

  // Pipeline side: drives EX/ID information, observes flags and redirect.
  modport master (
    output ex_valid, ex_opcode, alu_nvz, stall,
    output br_valid, br_ccc, br_target, pc_plus2,
    input  flags, br_taken, flush, redirect_pc
  );

  // Unit side.
  modport slave (
    input  ex_valid, ex_opcode, alu_nvz, stall,
    input  br_valid, br_ccc, br_target, pc_plus2,
    output flags, br_taken, flush, redirect_pc
  );

endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluator
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] nvz,
  output logic       taken
);

  logic w_n;
  logic w_v;
  logic w_z;

  assign w_n = nvz[FLAG_N];
  assign w_v = nvz[FLAG_V];
  assign w_z = nvz[FLAG_Z];

  // Map the condition code onto the flag predicate.
  always_comb begin
    taken = 1'b0;
    case (ccc_t'(ccc))
      CCC_NEQ:    taken = ~w_z;
      CCC_EQ:     taken = w_z;
      CCC_GT:     taken = ~w_z & ~w_n;
      CCC_LT:     taken = w_n;
      CCC_GTE:    taken = w_z | (~w_z & ~w_n);
      CCC_LTE:    taken = w_n | w_z;
      CCC_OVFL:   taken = w_v;
      CCC_UNCOND: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - N/V/Z flag register and branch resolution
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  flag_branch_unit_if.slave   bus
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_flags;
  logic [2:0]      w_eff_flags;
  flag_class_t     w_class;
  logic            w_flag_we;
  logic            w_cond_taken;
  logic            w_resolve;
  logic [PC_W-1:0] r_redirect_pc;
  logic [PC_W-1:0] w_redirect_nxt;

  assign w_class   = flag_class(bus.ex_opcode);
  assign w_flag_we = bus.ex_valid & ~bus.stall & (w_class != FC_NONE);

  // Flags as they will look after this edge; branches in ID see these.
  always_comb begin
    w_eff_flags = r_flags;
    if (w_flag_we) begin
      if (w_class == FC_ALL) begin
        w_eff_flags = bus.alu_nvz;
      end else begin
        w_eff_flags[FLAG_Z] = bus.alu_nvz[FLAG_Z];
      end
    end
  end

  branch_cond_eval u_cond (
    .ccc   (bus.br_ccc),
    .nvz   (w_eff_flags),
    .taken (w_cond_taken)
  );

  // Flag register; writes continue in REDIRECT since EX is older than the branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else begin
      r_flags <= w_eff_flags;
    end
  end

  // Next state and next redirect target; REDIRECT always lasts one cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_redirect_nxt = r_redirect_pc;
    w_resolve      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_resolve = bus.br_valid & ~bus.stall;
        if (w_resolve) begin
          if (w_cond_taken) begin
            w_state_nxt    = ST_REDIRECT;
            w_redirect_nxt = bus.br_target;
          end else begin
            w_redirect_nxt = bus.pc_plus2;
          end
        end
      end
      ST_REDIRECT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and redirect target registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_redirect_pc <= w_redirect_nxt;
    end
  end

  // br_taken/flush come straight from the state register, so they are registered.
  assign bus.flags       = r_flags;
  assign bus.br_taken    = (r_state == ST_REDIRECT);
  assign bus.flush       = (r_state == ST_REDIRECT);
  assign bus.redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed self-checking bench for flag_branch_unit
module tb_flag_branch_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  flag_branch_unit_if #(.PC_W(16)) bus ();

  flag_branch_unit #(.PC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid  = 1'b0;
    bus.ex_opcode = 4'b0000;
    bus.alu_nvz   = 3'b000;
    bus.stall     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_ccc    = 3'b000;
    bus.br_target = 16'h0000;
    bus.pc_plus2  = 16'h0000;
  endtask

  task automatic ex_op(input logic [3:0] op, input logic [2:0] nvz);
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = op;
    bus.alu_nvz   = nvz;
  endtask

  task automatic branch(input logic [2:0] ccc, input logic [15:0] tgt, input logic [15:0] pc2);
    bus.br_valid  = 1'b1;
    bus.br_ccc    = ccc;
    bus.br_target = tgt;
    bus.pc_plus2  = pc2;
  endtask

  // {nvz, ccc, expected taken}
  typedef struct {
    logic [2:0] nvz;
    logic [2:0] ccc;
    logic       exp;
  } cond_vec_t;

  cond_vec_t cond_tbl[10] = '{
    '{3'b000, 3'b000, 1'b1},
    '{3'b001, 3'b000, 1'b0},
    '{3'b100, 3'b010, 1'b0},
    '{3'b000, 3'b010, 1'b1},
    '{3'b100, 3'b100, 1'b0},
    '{3'b001, 3'b100, 1'b1},
    '{3'b100, 3'b101, 1'b1},
    '{3'b000, 3'b101, 1'b0},
    '{3'b010, 3'b110, 1'b1},
    '{3'b101, 3'b110, 1'b0}
  };

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.ex_valid  = 1'($urandom);
      bus.ex_opcode = 4'($urandom);
      bus.alu_nvz   = 3'($urandom);
      bus.stall     = 1'($urandom);
      bus.br_valid  = 1'($urandom);
      bus.br_ccc    = 3'($urandom);
      bus.br_target = 16'($urandom);
      bus.pc_plus2  = 16'($urandom);
      tick();
    end
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_taken", 32'(bus.br_taken), 32'h0);
    check("rst_pc", 32'(bus.redirect_pc), 32'h0);

    rst_n = 1'b1;
    idle_inputs();
    tick();

    // SUB then XOR: XOR writes Z only
    ex_op(4'b0001, 3'b110);
    tick();
    check("sub_flags", 32'(bus.flags), 32'h6);
    ex_op(4'b0010, 3'b001);
    tick();
    check("xor_flags", 32'(bus.flags), 32'h7);

    // Clear flags, then forwarding ADD Z=1 with EQ branch
    ex_op(4'b0000, 3'b000);
    tick();
    check("clr_flags", 32'(bus.flags), 32'h0);
    ex_op(4'b0000, 3'b001);
    branch(3'b001, 16'h0040, 16'h0022);
    tick();
    check("fwd_taken", 32'(bus.br_taken), 32'h1);
    check("fwd_flush", 32'(bus.flush), 32'h1);
    check("fwd_pc", 32'(bus.redirect_pc), 32'h0040);
    check("fwd_flags", 32'(bus.flags), 32'h1);
    idle_inputs();
    tick();
    check("fwd_flush_end", 32'(bus.flush), 32'h0);
    check("fwd_taken_end", 32'(bus.br_taken), 32'h0);
    check("fwd_pc_hold", 32'(bus.redirect_pc), 32'h0040);

    // Not taken LT with flags=000
    ex_op(4'b0000, 3'b000);
    tick();
    idle_inputs();
    branch(3'b011, 16'h0099, 16'h0012);
    tick();
    check("nt_taken", 32'(bus.br_taken), 32'h0);
    check("nt_flush", 32'(bus.flush), 32'h0);
    check("nt_pc", 32'(bus.redirect_pc), 32'h0012);

    // Stall: no resolution and no flag writes for 3 cycles
    branch(3'b111, 16'h0100, 16'h0102);
    bus.stall = 1'b1;
    ex_op(4'b0000, 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_flush", 32'(bus.flush), 32'h0);
      check("stall_flags", 32'(bus.flags), 32'h0);
      check("stall_pc", 32'(bus.redirect_pc), 32'h0012);
    end
    bus.stall    = 1'b0;
    bus.ex_valid = 1'b0;
    tick();
    check("unstall_flush", 32'(bus.flush), 32'h1);
    check("unstall_pc", 32'(bus.redirect_pc), 32'h0100);
    bus.br_valid = 1'b0;
    tick();
    check("unstall_flush_end", 32'(bus.flush), 32'h0);

    // Back-to-back: second branch in REDIRECT dropped, flag write still occurs
    branch(3'b111, 16'h0200, 16'h0202);
    tick();
    check("b2b_flush1", 32'(bus.flush), 32'h1);
    check("b2b_pc1", 32'(bus.redirect_pc), 32'h0200);
    branch(3'b111, 16'h0300, 16'h0302);
    ex_op(4'b0000, 3'b010);
    tick();
    check("b2b_drop_flush", 32'(bus.flush), 32'h0);
    check("b2b_drop_pc", 32'(bus.redirect_pc), 32'h0200);
    check("redir_flag_wr", 32'(bus.flags), 32'h2);

    // Branch arriving right after REDIRECT resolves normally (OVFL, V=1)
    bus.ex_valid = 1'b0;
    branch(3'b110, 16'h0400, 16'h0402);
    tick();
    check("after_redir_flush", 32'(bus.flush), 32'h1);
    check("after_redir_pc", 32'(bus.redirect_pc), 32'h0400);

    // Reset while in REDIRECT
    idle_inputs();
    rst_n = 1'b0;
    tick();
    check("rst_redir_flush", 32'(bus.flush), 32'h0);
    check("rst_redir_flags", 32'(bus.flags), 32'h0);
    check("rst_redir_pc", 32'(bus.redirect_pc), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_redir_idle", 32'(bus.flush), 32'h0);

    // No-write classes and ex_valid gating
    ex_op(4'b0000, 3'b101);
    tick();
    check("add_flags", 32'(bus.flags), 32'h5);
    ex_op(4'b0111, 3'b111);
    tick();
    check("paddsb_flags", 32'(bus.flags), 32'h5);
    ex_op(4'b0011, 3'b010);
    tick();
    check("red_flags", 32'(bus.flags), 32'h5);
    ex_op(4'b1000, 3'b000);
    tick();
    check("op1xxx_flags", 32'(bus.flags), 32'h5);
    bus.ex_valid  = 1'b0;
    bus.ex_opcode = 4'b0000;
    bus.alu_nvz   = 3'b010;
    tick();
    check("bubble_flags", 32'(bus.flags), 32'h5);
    ex_op(4'b0101, 3'b010);
    tick();
    check("sra_flags", 32'(bus.flags), 32'h4);

    // Condition table via forwarded ADD flags
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      ex_op(4'b0000, cond_tbl[i].nvz);
      branch(cond_tbl[i].ccc, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      tick();
      check($sformatf("cond%0d_taken", i), 32'(bus.br_taken), 32'(cond_tbl[i].exp));
      check($sformatf("cond%0d_pc", i), 32'(bus.redirect_pc),
            cond_tbl[i].exp ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
      idle_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
